// File: rtl/timer_pkg.sv
// Shared timer package.
// Holds the BCD converter FSM encoding and the 7-segment constants used by
// every display consumer in the timer. Segment bit order is {g,f,e,d,c,b,a},
// active-high; any polarity inversion happens at the consumer's pin register.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'h40;  // segment g only
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Largest count that has a two-digit decimal representation.
    localparam logic [7:0] COUNT_MAX = 8'd99;

endpackage

// File: rtl/bcd_display_driver_if.sv
// Bus between the timer counter stage and the BCD display driver.
//   count      binary count from the counter (driven by master)
//   bcd_tens   published tens digit
//   bcd_ones   published ones digit
//   ovf        last captured count was above 99
//   valid      bcd_* match the current count, no conversion pending
//   seg        segment pins {g,f,e,d,c,b,a} of the enabled digit
//   an         digit enables, an[0]=ones, an[1]=tens
//   fsm_state  converter FSM state, exposed for observation only
// Handshake: there is no valid/ready pair. count is a level the driver samples
// whenever its FSM is idle; valid is a pure status flag that is high only while
// the published digits belong to the count currently on the bus, and it never
// back-pressures the counter.
interface bcd_display_driver_if;
    import timer_pkg::*;

    logic [7:0] count;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    logic       valid;
    logic [6:0] seg;
    logic [1:0] an;
    state_t     fsm_state;

    modport master (
        output count,
        input  bcd_tens, bcd_ones, ovf, valid, seg, an, fsm_state
    );

    modport slave (
        input  count,
        output bcd_tens, bcd_ones, ovf, valid, seg, an, fsm_state
    );

endinterface

// File: rtl/bcd_display_driver_seg7_decode.sv
// seg7_decode: combinational BCD digit to 7-segment pattern.
//   bcd  in  4  digit 0..9
//   seg  out 7  active-high {g,f,e,d,c,b,a}; codes 10..15 map to blank
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: converts the 0..99 binary timer count into two BCD digits
// with a sequential shift-add-3 engine and time-multiplexes them onto a shared
// 7-segment bus.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of bcd_display_driver_if (count in; digits, status,
//          segment/anode pins and FSM state out)
// Parameters:
//   REFRESH_DIV  cycles each digit stays enabled (>=2)
//   ACTIVE_LOW   1: seg/an pins active-low
//   BLANK_LZ     1: blank a zero tens digit
module bcd_display_driver
    import timer_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_display_driver_if.slave    bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    // Pin values while in reset: ones slot showing "0".
    localparam logic [6:0] SEG_RST = ACTIVE_LOW ? ~SEG_DIGIT[0] : SEG_DIGIT[0];
    localparam logic [1:0] AN_RST  = ACTIVE_LOW ? 2'b10 : 2'b01;

    state_t        state_q, state_d;
    logic          force_q, force_d;
    logic [7:0]    last_q, last_d;
    logic [15:0]   shift_q, shift_d;     // {tens, ones, binary}
    logic [2:0]    iter_q, iter_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;         // 0: ones slot, 1: tens slot
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          start;
    logic [3:0]    tens_adj, ones_adj;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic [6:0]    pat;
    logic [1:0]    an_pat;

    // A conversion starts when the count differs from the last captured
    // value, or unconditionally once after reset.
    assign start = force_q || (bus.count != last_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            force_q <= 1'b1;
            last_q  <= 8'd0;
            shift_q <= 16'd0;
            iter_q  <= 3'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ref_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_RST;
            an_q    <= AN_RST;
        end else begin
            state_q <= state_d;
            force_q <= force_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (iter_q == 3'd7) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- converter datapath ----------------
    always_comb begin
        force_d = force_q;
        last_d  = last_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        // Add-3 correction applied before each left shift.
        tens_adj = (shift_q[15:12] >= 4'd5) ? shift_q[15:12] + 4'd3 : shift_q[15:12];
        ones_adj = (shift_q[11:8]  >= 4'd5) ? shift_q[11:8]  + 4'd3 : shift_q[11:8];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = {8'd0, bus.count};
                    last_d  = bus.count;
                    force_d = 1'b0;
                    iter_d  = 3'd0;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Tens carry-out only happens for counts >99, which publish 0.
                shift_d = {tens_adj[2:0], ones_adj, shift_q[7:0], 1'b0};
                iter_d  = iter_q + 3'd1;
            end
            ST_DONE: begin
                if (last_q > COUNT_MAX) begin
                    ovf_d  = 1'b1;
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else begin
                    ovf_d  = 1'b0;
                    tens_d = shift_q[15:12];
                    ones_d = shift_q[11:8];
                end
            end
            default: ;
        endcase
    end

    // ---------------- display multiplexer ----------------
    seg7_decode u_seg7_decode (
        .bcd (digit),
        .seg (dec_seg)
    );

    // The pin register is fed from next-cycle values, so its contents only
    // move when the slot toggles or new digits are published.
    always_comb begin
        ref_d  = (ref_q == REF_LAST) ? '0 : ref_q + RW'(1);
        sel_d  = (ref_q == REF_LAST) ? ~sel_q : sel_q;
        digit  = sel_d ? tens_d : ones_d;

        if (ovf_d) begin
            pat = SEG_DASH;
        end else if (sel_d && BLANK_LZ && (tens_d == 4'd0)) begin
            pat = SEG_BLANK;
        end else begin
            pat = dec_seg;
        end

        an_pat = sel_d ? 2'b10 : 2'b01;
        seg_d  = ACTIVE_LOW ? ~pat : pat;
        an_d   = ACTIVE_LOW ? ~an_pat : an_pat;
    end

    // ---------------- outputs ----------------
    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_ones  = ones_q;
    assign bus.ovf       = ovf_q;
    assign bus.valid     = valid_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver (REFRESH_DIV=4, active-low pins,
// leading-zero blanking).
module tb_bcd_display_driver;
  import timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bcd_display_driver_if bus ();

  bcd_display_driver #(
    .REFRESH_DIV (4),
    .ACTIVE_LOW  (1'b1),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Active-high view of the pins.
  logic [6:0] seg_ah;
  logic [1:0] an_ah;
  assign seg_ah = ~bus.seg;
  assign an_ah  = ~bus.an;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];     // {ovf, tens, ones}
  logic [7:0] cur_count;
  logic       pub_pend = 1'b0;
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] v);
    if (v > 8'd99) return 9'h100;
    return {1'b0, 4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Publish monitor: the edge after DONE loads the digits.
  always @(negedge clk) begin
    if (!reset) begin
      pub_pend = 1'b0;
    end else begin
      if (pub_pend) begin
        if (exp_q.size() == 0) begin
          check("pub_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pub_ovf",  32'(bus.ovf),      32'(mon_e[8]));
          check("pub_tens", 32'(bus.bcd_tens), 32'(mon_e[7:4]));
          check("pub_ones", 32'(bus.bcd_ones), 32'(mon_e[3:0]));
        end
      end
      pub_pend = (bus.fsm_state == ST_DONE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    if (v != cur_count) exp_q.push_back(model(v));
    cur_count = v;
    bus.count = v;
  endtask

  task automatic wait_an(input logic [1:0] want, input string tag);
    int k = 0;
    while (an_ah !== want && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (an_ah !== want) check({tag, "_an_timeout"}, 32'(an_ah), 32'(want));
  endtask

  task automatic check_display(input string tag, input logic [6:0] tens_seg,
                               input logic [6:0] ones_seg);
    wait_an(2'b10, tag);
    check({tag, "_tens_seg"}, 32'(seg_ah), 32'(tens_seg));
    wait_an(2'b01, tag);
    check({tag, "_ones_seg"}, 32'(seg_ah), 32'(ones_seg));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bus.count = 8'd0;
    cur_count = 8'd0;

    // Test 1: reset state, forced first conversion of 0
    repeat (3) @(negedge clk);
    check("t1_rst_tens",  32'(bus.bcd_tens), 32'd0);
    check("t1_rst_ones",  32'(bus.bcd_ones), 32'd0);
    check("t1_rst_ovf",   32'(bus.ovf),      32'd0);
    check("t1_rst_valid", 32'(bus.valid),    32'd0);
    check("t1_rst_seg",   32'(seg_ah),       32'h3F);
    check("t1_rst_an",    32'(an_ah),        32'h1);
    reset = 1'b1;
    exp_q.push_back(model(8'd0));
    repeat (11) @(negedge clk);
    check("t1_valid", 32'(bus.valid),    32'd1);
    check("t1_tens",  32'(bus.bcd_tens), 32'd0);
    check("t1_ones",  32'(bus.bcd_ones), 32'd0);
    check_display("t1", 7'h00, 7'h3F);

    // Test 2: 0 -> 57, exact latency and refresh period
    drive(8'd57);
    @(negedge clk);
    check("t2_valid_drop", 32'(bus.valid), 32'd0);
    repeat (8) @(negedge clk);
    check("t2_not_early", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
    @(negedge clk);
    check("t2_tens", 32'(bus.bcd_tens), 32'd5);
    check("t2_ones", 32'(bus.bcd_ones), 32'd7);
    repeat (2) @(negedge clk);
    check("t2_valid", 32'(bus.valid), 32'd1);
    check_display("t2", seg_of(5), seg_of(7));
    wait_an(2'b01, "t2p");
    wait_an(2'b10, "t2p");
    k = 0;
    while (an_ah == 2'b10 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t2_refresh_period", 32'(k), 32'd4);

    // Test 3: sweep 0..99 then wrap to 0
    for (int v = 0; v < 100; v++) begin
      drive(8'(v));
      repeat (12) @(negedge clk);
      check("t3_valid", 32'(bus.valid), 32'd1);
      if (v == 5)  check_display("t3_5",  7'h00, seg_of(5));
      if (v == 99) check_display("t3_99", seg_of(9), seg_of(9));
    end
    drive(8'd0);
    repeat (12) @(negedge clk);
    check("t3_wrap_bcd", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
    check_display("t3_wrap", 7'h00, 7'h3F);

    // Test 4: out of range, then back in range
    drive(8'd150);
    repeat (12) @(negedge clk);
    check("t4_ovf", 32'(bus.ovf), 32'd1);
    check("t4_bcd", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h00);
    check_display("t4", 7'h40, 7'h40);
    drive(8'd42);
    repeat (12) @(negedge clk);
    check("t4_ovf_clr", 32'(bus.ovf), 32'd0);
    check("t4_bcd42", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h42);
    check_display("t4_42", seg_of(4), seg_of(2));

    // Test 5: count changes mid-conversion (before E3)
    drive(8'd12);
    repeat (3) @(negedge clk);
    check("t5_in_shift", 32'(bus.fsm_state), 32'(ST_SHIFT));
    bus.count = 8'd34;
    cur_count = 8'd34;
    exp_q.push_back(model(8'd34));
    repeat (25) @(negedge clk);
    check("t5_valid", 32'(bus.valid), 32'd1);
    check("t5_bcd", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h34);

    // Test 6: async reset during SHIFT, restart after release
    drive(8'd77);
    repeat (4) @(negedge clk);
    check("t6_in_shift", 32'(bus.fsm_state), 32'(ST_SHIFT));
    reset = 1'b0;
    #1;
    check("t6_rst_tens",  32'(bus.bcd_tens),  32'd0);
    check("t6_rst_ones",  32'(bus.bcd_ones),  32'd0);
    check("t6_rst_valid", 32'(bus.valid),     32'd0);
    check("t6_rst_ovf",   32'(bus.ovf),       32'd0);
    check("t6_rst_seg_pin", 32'(bus.seg),     32'h40);
    check("t6_rst_an_pin",  32'(bus.an),      32'h2);
    check("t6_rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(model(8'd77));
    repeat (12) @(negedge clk);
    check("t6_valid", 32'(bus.valid), 32'd1);
    check("t6_bcd", 32'({bus.bcd_tens, bus.bcd_ones}), 32'h77);
    check_display("t6", seg_of(7), seg_of(7));

    check("q_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
